// File: rtl/turf_udp_pkg.sv
// turf_udp_pkg -- shared definitions for the UDP encapsulator.
//   state_e       : encapsulator FSM state encoding
//   UDP_HDR_BYTES : UDP header size in bytes
//   UDP_HDR_LEN   : the same value as a 16-bit quantity, for the length field
//   pack_udp_hdr  : builds the 8-byte UDP header as one 64-bit beat.
//                   Network byte 0 is placed at [7:0].
package turf_udp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2
   } state_e;

   localparam int unsigned UDP_HDR_BYTES = 8;
   localparam logic [15:0] UDP_HDR_LEN   = 16'(UDP_HDR_BYTES);

   function automatic logic [63:0] pack_udp_hdr(input logic [15:0] src_port,
                                                input logic [15:0] dst_port,
                                                input logic [15:0] udp_len,
                                                input logic [15:0] csum);
      logic [63:0] be_word;
      logic [63:0] beat;
      // be_word holds the header as it reads on the wire, with byte 0 in the top byte.
      // The loop reverses the byte order so that byte 0 lands in the lowest lane.
      be_word = {src_port, dst_port, udp_len, csum};
      beat    = '0;
      for (int i = 0; i < 8; i++) begin
         beat[i*8 +: 8] = be_word[(7-i)*8 +: 8];
      end
      return beat;
   endfunction

endpackage

// File: rtl/turf_keep_popcount.sv
// turf_keep_popcount -- counts the valid bytes in one 64-bit beat.
//   keep_i  [7:0] : AXI-stream tkeep
//   count_o [3:0] : number of set bits in keep_i (0..8)
module turf_keep_popcount (
   input  logic [7:0] keep_i,
   output logic [3:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < 8; i++) begin
         count_o = count_o + {3'b000, keep_i[i]};
      end
   end

endmodule

// File: rtl/turf_udp_encap.sv
// turf_udp_encap -- prepends a UDP header to a payload stream.
//   aclk, aresetn       : clock; synchronous active-low reset
//   s_hdr_*             : header request {dst IP, dst port, payload length}
//                         and source port on tuser
//   s_payload_*         : 64-bit payload stream
//   m_udp_*             : UDP datagram stream; tuser carries the dst IP
//   err_o, err_count_o  : sticky length-mismatch flag and saturating count
// Optional build macro TURF_UDP_ENCAP_LENCHK_EN enables the payload length check.
// If the macro is not defined, err_o and err_count_o are tied to 0.
//
//   state   | meaning
//   IDLE    | waiting for a header request; payload is held off
//   HDR     | presenting the UDP header beat
//   PAYLOAD | payload passes through combinationally until tlast
module turf_udp_encap
   import turf_udp_pkg::*;
#(
   parameter logic [15:0] UDP_CHECKSUM = 16'h0000
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [63:0] s_hdr_tdata,
   input  logic [15:0] s_hdr_tuser,
   input  logic        s_hdr_tvalid,
   output logic        s_hdr_tready,
   input  logic [63:0] s_payload_tdata,
   input  logic [7:0]  s_payload_tkeep,
   input  logic        s_payload_tlast,
   input  logic        s_payload_tvalid,
   output logic        s_payload_tready,
   output logic [63:0] m_udp_tdata,
   output logic [7:0]  m_udp_tkeep,
   output logic        m_udp_tlast,
   output logic        m_udp_tvalid,
   input  logic        m_udp_tready,
   output logic [31:0] m_udp_tuser,
   output logic        err_o,
   output logic [7:0]  err_count_o
);

   state_e      state_q, state_d;
   logic [31:0] ip_q, ip_d;
   logic [15:0] dport_q, dport_d;
   logic [15:0] len_q, len_d;
   logic [15:0] sport_q, sport_d;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= IDLE;
         ip_q    <= '0;
         dport_q <= '0;
         len_q   <= '0;
         sport_q <= '0;
      end else begin
         state_q <= state_d;
         ip_q    <= ip_d;
         dport_q <= dport_d;
         len_q   <= len_d;
         sport_q <= sport_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      ip_d             = ip_q;
      dport_d          = dport_q;
      len_d            = len_q;
      sport_d          = sport_q;
      s_hdr_tready     = 1'b0;
      s_payload_tready = 1'b0;
      m_udp_tvalid     = 1'b0;
      m_udp_tdata      = '0;
      m_udp_tkeep      = '0;
      m_udp_tlast      = 1'b0;
      case (state_q)
         IDLE: begin
            s_hdr_tready = 1'b1;
            if (s_hdr_tvalid) begin
               ip_d    = s_hdr_tdata[63:32];
               dport_d = s_hdr_tdata[31:16];
               len_d   = s_hdr_tdata[15:0];
               sport_d = s_hdr_tuser;
               state_d = HDR;
            end
         end
         HDR: begin
            m_udp_tvalid = 1'b1;
            m_udp_tkeep  = 8'hFF;
            // The length field wraps modulo 2^16. Keeping a length that does not wrap is the upstream's job.
            m_udp_tdata  = pack_udp_hdr(sport_q, dport_q, len_q + UDP_HDR_LEN, UDP_CHECKSUM);
            m_udp_tlast  = (len_q == 16'd0);
            if (m_udp_tready) begin
               state_d = (len_q == 16'd0) ? IDLE : PAYLOAD;
            end
         end
         PAYLOAD: begin
            m_udp_tvalid     = s_payload_tvalid;
            s_payload_tready = m_udp_tready;
            m_udp_tdata      = s_payload_tdata;
            m_udp_tkeep      = s_payload_tkeep;
            m_udp_tlast      = s_payload_tlast;
            if (s_payload_tvalid && m_udp_tready && s_payload_tlast) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // The state register only clears at the next edge. Until then, mask the
      // handshakes so that a half-sent datagram stops at once and nothing is consumed.
      if (!aresetn) begin
         s_hdr_tready     = 1'b0;
         s_payload_tready = 1'b0;
         m_udp_tvalid     = 1'b0;
      end
   end

   assign m_udp_tuser = ip_q;

`ifdef TURF_UDP_ENCAP_LENCHK_EN
   logic [3:0]  beat_bytes;
   logic        pay_fire;
   logic [16:0] byte_sum;
   logic [15:0] byte_acc;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic        err_q, err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   turf_keep_popcount u_keep_popcount (
      .keep_i  (s_payload_tkeep),
      .count_o (beat_bytes)
   );

   assign pay_fire = (state_q == PAYLOAD) && s_payload_tvalid && m_udp_tready && aresetn;

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      err_d      = err_q;
      err_cnt_d  = err_cnt_q;
      byte_sum   = {1'b0, byte_cnt_q} + {13'd0, beat_bytes};
      byte_acc   = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
      if (state_q == IDLE) begin
         byte_cnt_d = '0;
      end
      if (pay_fire) begin
         byte_cnt_d = byte_acc;
         if (s_payload_tlast) begin
            byte_cnt_d = '0;
            if (byte_acc != len_q) begin
               err_d = 1'b1;
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         byte_cnt_q <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign err_o       = err_q;
   assign err_count_o = err_cnt_q;
`else
   assign err_o       = 1'b0;
   assign err_count_o = 8'h00;
`endif

endmodule

// File: tb/tb_turf_udp_encap.sv
// tb_turf_udp_encap -- directed and randomized checks for turf_udp_encap.
// Inputs change 1 time unit after the rising edge. Outputs are sampled 1 time unit later.
module tb_turf_udp_encap;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [63:0] s_hdr_tdata;
   logic [15:0] s_hdr_tuser;
   logic        s_hdr_tvalid;
   logic        s_hdr_tready;
   logic [63:0] s_payload_tdata;
   logic [7:0]  s_payload_tkeep;
   logic        s_payload_tlast;
   logic        s_payload_tvalid;
   logic        s_payload_tready;
   logic [63:0] m_udp_tdata;
   logic [7:0]  m_udp_tkeep;
   logic        m_udp_tlast;
   logic        m_udp_tvalid;
   logic        m_udp_tready;
   logic [31:0] m_udp_tuser;
   logic        err_o;
   logic [7:0]  err_count_o;

   turf_udp_encap dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .s_hdr_tdata      (s_hdr_tdata),
      .s_hdr_tuser      (s_hdr_tuser),
      .s_hdr_tvalid     (s_hdr_tvalid),
      .s_hdr_tready     (s_hdr_tready),
      .s_payload_tdata  (s_payload_tdata),
      .s_payload_tkeep  (s_payload_tkeep),
      .s_payload_tlast  (s_payload_tlast),
      .s_payload_tvalid (s_payload_tvalid),
      .s_payload_tready (s_payload_tready),
      .m_udp_tdata      (m_udp_tdata),
      .m_udp_tkeep      (m_udp_tkeep),
      .m_udp_tlast      (m_udp_tlast),
      .m_udp_tvalid     (m_udp_tvalid),
      .m_udp_tready     (m_udp_tready),
      .m_udp_tuser      (m_udp_tuser),
      .err_o            (err_o),
      .err_count_o      (err_count_o)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_hdr(input logic [31:0] ip, input logic [15:0] dport,
                            input logic [15:0] len, input logic [15:0] sport);
      s_hdr_tdata  = {ip, dport, len};
      s_hdr_tuser  = sport;
      s_hdr_tvalid = 1'b1;
   endtask

   task automatic drive_pay(input logic [63:0] d, input logic [7:0] k, input logic l);
      s_payload_tdata  = d;
      s_payload_tkeep  = k;
      s_payload_tlast  = l;
      s_payload_tvalid = 1'b1;
   endtask

   // Reference header beat: network byte 0 (source port MSB) goes in the lowest lane. Checksum is 0 by default.
   function automatic logic [63:0] model_hdr(input logic [15:0] src, input logic [15:0] dst,
                                             input logic [15:0] len);
      logic [15:0] l8;
      l8 = len + 16'd8;
      return {8'h00, 8'h00, l8[7:0], l8[15:8], dst[7:0], dst[15:8], src[7:0], src[15:8]};
   endfunction

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic [31:0] u;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       pay_q[$];
   logic [63:0] hd_q[$];
   logic [15:0] hu_q[$];

   initial begin
      beat_t       e;
      beat_t       p;
      logic [31:0] ip;
      logic [15:0] dst, src, len;
      int          nb, rem, hi, pi, cycles;

      aresetn          = 1'b0;
      s_hdr_tdata      = '0;
      s_hdr_tuser      = '0;
      s_hdr_tvalid     = 1'b0;
      s_payload_tdata  = '0;
      s_payload_tkeep  = '0;
      s_payload_tlast  = 1'b0;
      s_payload_tvalid = 1'b0;
      m_udp_tready     = 1'b1;

      // ---- reset state ----
      repeat (3) step();
      check("rst_tvalid", m_udp_tvalid, 1'b0);
      check("rst_err", err_o, 1'b0);
      check("rst_errcnt", err_count_o, 8'h00);
      check("rst_pready", s_payload_tready, 1'b0);
      aresetn = 1'b1;
      step();
      check("idle_hready", s_hdr_tready, 1'b1);
      check("idle_tvalid", m_udp_tvalid, 1'b0);

      // ---- basic datagram: 24 bytes, 3 full beats ----
      drive_hdr(32'h0A000001, 16'h1234, 16'd24, 16'h5430);
      settle();
      check("a_idle_hready", s_hdr_tready, 1'b1);
      step();
      s_hdr_tvalid = 1'b0;
      drive_pay(64'h0807060504030201, 8'hFF, 1'b0);
      settle();
      check("a_hdr_valid", m_udp_tvalid, 1'b1);
      check("a_hdr_data", m_udp_tdata, 64'h0000_2000_3412_3054);
      check("a_hdr_keep", m_udp_tkeep, 8'hFF);
      check("a_hdr_last", m_udp_tlast, 1'b0);
      check("a_hdr_user", m_udp_tuser, 32'h0A000001);
      check("a_hdr_pay_held", s_payload_tready, 1'b0);
      step();
      settle();
      check("a_b1", {m_udp_tvalid, m_udp_tdata, m_udp_tlast, m_udp_tuser},
            {1'b1, 64'h0807060504030201, 1'b0, 32'h0A000001});
      step();
      drive_pay(64'h100F0E0D0C0B0A09, 8'hFF, 1'b0);
      settle();
      check("a_b2", {m_udp_tvalid, m_udp_tdata, m_udp_tlast, m_udp_tuser},
            {1'b1, 64'h100F0E0D0C0B0A09, 1'b0, 32'h0A000001});
      step();
      drive_pay(64'h1817161514131211, 8'hFF, 1'b1);
      settle();
      check("a_b3", {m_udp_tvalid, m_udp_tdata, m_udp_tlast, m_udp_tuser},
            {1'b1, 64'h1817161514131211, 1'b1, 32'h0A000001});
      step();
      s_payload_tvalid = 1'b0;
      settle();
      check("a_back_idle", {m_udp_tvalid, s_hdr_tready}, 2'b01);

      // ---- zero-length datagram, with payload offered that must not be taken ----
      drive_hdr(32'hC0A80101, 16'h0050, 16'd0, 16'h1F90);
      drive_pay(64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1);
      step();
      s_hdr_tvalid = 1'b0;
      m_udp_tready = 1'b0;
      settle();
      check("b_hdr_data", m_udp_tdata, 64'h0000_0800_5000_901F);
      check("b_hdr_last", m_udp_tlast, 1'b1);
      check("b_pay_held", s_payload_tready, 1'b0);
      step();
      m_udp_tready = 1'b1;
      settle();
      check("b_stall_hold", {m_udp_tvalid, m_udp_tdata}, {1'b1, 64'h0000_0800_5000_901F});
      step();
      settle();
      check("b_idle", {m_udp_tvalid, s_payload_tready, s_hdr_tready}, 3'b001);
      s_payload_tvalid = 1'b0;

      // ---- length wrap boundary: 0xFFF8 + 8 wraps to 0 ----
      drive_hdr(32'h01010101, 16'h0002, 16'hFFF8, 16'h0001);
      step();
      s_hdr_tvalid = 1'b0;
      settle();
      check("w_hdr_data", m_udp_tdata, 64'h0000_0000_0200_0100);
      check("w_hdr_last", m_udp_tlast, 1'b0);
      aresetn = 1'b0;
      step();
      aresetn = 1'b1;
      settle();
      check("w_after_rst", {m_udp_tvalid, s_hdr_tready}, 2'b01);

      // ---- back-to-back headers ----
      drive_hdr(32'h01020304, 16'h1111, 16'd8, 16'h2222);
      step();
      drive_hdr(32'h05060708, 16'h3333, 16'd0, 16'h4444);
      settle();
      check("c_hdr2_held_hdr", s_hdr_tready, 1'b0);
      step();
      drive_pay(64'hA5A5A5A5A5A5A5A5, 8'hFF, 1'b1);
      settle();
      check("c_hdr2_held_pay", s_hdr_tready, 1'b0);
      check("c_pay", {m_udp_tdata, m_udp_tlast}, {64'hA5A5A5A5A5A5A5A5, 1'b1});
      step();
      s_payload_tvalid = 1'b0;
      settle();
      check("c_hdr2_accept", {s_hdr_tready, m_udp_tvalid}, 2'b10);
      step();
      s_hdr_tvalid = 1'b0;
      settle();
      check("c_hdr2_beat", {m_udp_tvalid, m_udp_tdata, m_udp_tlast, m_udp_tuser},
            {1'b1, 64'h0000_0800_3333_4444, 1'b1, 32'h05060708});
      step();
      settle();
      check("c_idle", m_udp_tvalid, 1'b0);

      // ---- length mismatch: 16 declared, 20 sent ----
      drive_hdr(32'h0B0B0B0B, 16'h0101, 16'd16, 16'h0202);
      step();
      s_hdr_tvalid = 1'b0;
      settle();
      check("e_hdr", m_udp_tdata, 64'h0000_1800_0101_0202);
      step();
      drive_pay(64'h1111111111111111, 8'hFF, 1'b0);
      settle();
      check("e_b1", {m_udp_tdata, m_udp_tkeep, m_udp_tlast}, {64'h1111111111111111, 8'hFF, 1'b0});
      step();
      drive_pay(64'h2222222222222222, 8'hFF, 1'b0);
      settle();
      check("e_b2", {m_udp_tdata, m_udp_tkeep, m_udp_tlast}, {64'h2222222222222222, 8'hFF, 1'b0});
      check("e_err_pre", err_o, 1'b0);
      step();
      drive_pay(64'h0000000033333333, 8'h0F, 1'b1);
      settle();
      check("e_b3", {m_udp_tdata, m_udp_tkeep, m_udp_tlast}, {64'h0000000033333333, 8'h0F, 1'b1});
      step();
      s_payload_tvalid = 1'b0;
      settle();
`ifdef TURF_UDP_ENCAP_LENCHK_EN
      check("e_err", err_o, 1'b1);
      check("e_errcnt", err_count_o, 8'd1);
`else
      check("e_err_tied", err_o, 1'b0);
      check("e_errcnt_tied", err_count_o, 8'd0);
`endif

      // ---- reset in the middle of a datagram ----
      drive_hdr(32'hAC100001, 16'h0035, 16'd40, 16'h8000);
      step();
      s_hdr_tvalid = 1'b0;
      settle();
      check("d_hdr", m_udp_tdata, 64'h0000_3000_3500_0080);
      step();
      drive_pay(64'h0101010101010101, 8'hFF, 1'b0);
      step();
      drive_pay(64'h0202020202020202, 8'hFF, 1'b0);
      step();
      drive_pay(64'h0303030303030303, 8'hFF, 1'b0);
      aresetn = 1'b0;
      settle();
      check("d_rst_gate", {m_udp_tvalid, s_payload_tready}, 2'b00);
      step();
      check("d_rst_state", {m_udp_tvalid, m_udp_tlast, err_o, err_count_o}, {1'b0, 1'b0, 1'b0, 8'h00});
      aresetn = 1'b1;
      settle();
      check("d_after_rst", {s_hdr_tready, s_payload_tready, m_udp_tvalid}, 3'b100);
      drive_hdr(32'h0A0000FE, 16'h0007, 16'd8, 16'h0009);
      drive_pay(64'hCAFEF00DCAFEF00D, 8'hFF, 1'b1);
      step();
      s_hdr_tvalid = 1'b0;
      settle();
      check("d_new_hdr", {m_udp_tvalid, m_udp_tdata, m_udp_tlast, m_udp_tuser, s_payload_tready},
            {1'b1, 64'h0000_1000_0700_0900, 1'b0, 32'h0A0000FE, 1'b0});
      step();
      settle();
      check("d_new_pay", {m_udp_tvalid, m_udp_tdata, m_udp_tlast}, {1'b1, 64'hCAFEF00DCAFEF00D, 1'b1});
      step();
      s_payload_tvalid = 1'b0;
      settle();
      check("d_new_idle", m_udp_tvalid, 1'b0);

      // ---- randomized throttling over 1000 datagrams ----
      for (int n = 0; n < 1000; n++) begin
         ip  = $urandom;
         dst = 16'($urandom_range(0, 65535));
         src = 16'($urandom_range(0, 65535));
         len = 16'($urandom_range(0, 48));
         hd_q.push_back({ip, dst, len});
         hu_q.push_back(src);
         e.d = model_hdr(src, dst, len);
         e.k = 8'hFF;
         e.l = (len == 16'd0);
         e.u = ip;
         exp_q.push_back(e);
         nb = (int'(len) + 7) / 8;
         for (int b = 0; b < nb; b++) begin
            rem = int'(len) - 8 * b;
            p.d = {$urandom, $urandom};
            p.k = (rem >= 8) ? 8'hFF : 8'(8'hFF >> (8 - rem));
            p.l = (b == nb - 1);
            p.u = ip;
            pay_q.push_back(p);
            exp_q.push_back(p);
         end
      end
      hi = 0;
      pi = 0;
      cycles = 0;
      while (exp_q.size() > 0 && cycles < 60000) begin
         step();
         s_hdr_tvalid = (hi < hd_q.size());
         if (hi < hd_q.size()) begin
            s_hdr_tdata = hd_q[hi];
            s_hdr_tuser = hu_q[hi];
         end
         s_payload_tvalid = (pi < pay_q.size()) && ($urandom_range(0, 9) < 7);
         if (pi < pay_q.size()) begin
            s_payload_tdata = pay_q[pi].d;
            s_payload_tkeep = pay_q[pi].k;
            s_payload_tlast = pay_q[pi].l;
         end
         m_udp_tready = ($urandom_range(0, 1) == 1);
         settle();
         if (s_hdr_tvalid && s_hdr_tready) hi++;
         if (s_payload_tvalid && s_payload_tready) pi++;
         if (m_udp_tvalid && m_udp_tready) begin
            e = exp_q.pop_front();
            check("rnd_beat", {m_udp_tdata, m_udp_tkeep, m_udp_tlast, m_udp_tuser},
                  {e.d, e.k, e.l, e.u});
         end
         cycles++;
      end
      check("rnd_drained", exp_q.size(), 0);
      check("rnd_pay_used", pi, pay_q.size());
      check("rnd_hdr_used", hi, hd_q.size());
      step();
      s_hdr_tvalid     = 1'b0;
      s_payload_tvalid = 1'b0;
      settle();
      check("rnd_errcnt", err_count_o, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
